// File: rtl/mem_ctrl.sv
// mem_ctrl: owner of the single byte-wide RAM port.
//
// Shares the RAM between the instruction fetcher (word reads only) and the
// load/store buffer (1/2/4-byte loads and stores). Each granted access is
// split into byte transfers on consecutive cycles. Read bytes are assembled
// little-endian and zero-extended. Completion is a one-cycle ok pulse to the
// requester.
//
// Arbitration is round-robin when both sides request. A ROB flush aborts an
// in-flight read. A write that has started always runs to completion.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   rdy                  global enable; low freezes all state, mem_wr reads 0
//   from_if_*            fetch request (level) and address
//   to_if_ok/to_if_data  fetch completion pulse and fetched word
//   from_lsb_*           LSB request, direction, length-1, address, store data
//   to_lsb_ok/to_lsb_data LSB completion pulse and zero-extended load data
//   from_rob_set         flush / mispredict
//   mem_din/mem_dout/mem_a/mem_wr   RAM port (1-cycle read latency)
//   io_buffer_full       I/O write buffer full
//
// Optional feature: define MCTR_IO_STALL_EN to hold write bytes that target
// the I/O region (addr[17:16] == IO_BASE_HI) while io_buffer_full is high.
// When the macro is undefined, io_buffer_full is ignored.

module mem_ctrl #(
    parameter logic [1:0] IO_BASE_HI = 2'b11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        from_if_ready,
    input  logic [31:0] from_if_addr,
    output logic        to_if_ok,
    output logic [31:0] to_if_data,
    input  logic        from_lsb_ready,
    input  logic        from_lsb_wr,
    input  logic [1:0]  from_lsb_len,
    input  logic [31:0] from_lsb_addr,
    input  logic [31:0] from_lsb_data,
    output logic        to_lsb_ok,
    output logic [31:0] to_lsb_data,
    input  logic        from_rob_set,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;

    logic [1:0]  state_reg;
    logic [2:0]  idx_reg;          // READ: step number; WRITE: bytes issued
    logic [31:0] base_reg;
    logic [1:0]  len_reg;
    logic [31:0] wdata_reg;
    logic        owner_reg;        // 1 = LSB, 0 = IF
    logic        last_grant_reg;   // 1 = LSB, 0 = IF
    logic [31:0] rbuf_reg;
    logic        mem_wr_reg;
    logic [31:0] mem_a_reg;
    logic [7:0]  mem_dout_reg;
    logic        to_if_ok_reg;
    logic        to_lsb_ok_reg;
    logic [31:0] to_if_data_reg;
    logic [31:0] to_lsb_data_reg;
    logic        rdy_prev_reg;
    logic [7:0]  skid_reg;

    assign to_if_ok    = to_if_ok_reg;
    assign to_lsb_ok   = to_lsb_ok_reg;
    assign to_if_data  = to_if_data_reg;
    assign to_lsb_data = to_lsb_data_reg;
    assign mem_a       = mem_a_reg;
    assign mem_dout    = mem_dout_reg;
    assign mem_wr      = mem_wr_reg & rdy;

    logic [2:0]  nbytes;
    logic [2:0]  last_step;
    logic [31:0] cur_addr;
    assign nbytes    = {1'b0, len_reg} + 3'd1;
    assign last_step = nbytes + 3'd1;
    assign cur_addr  = base_reg + {29'd0, idx_reg};

    // The RAM keeps clocking while rdy is low, so after the first frozen edge
    // mem_din already shows the byte one address ahead. The byte that was due
    // at that edge is parked in skid_reg and consumed on the first live edge.
    logic [7:0] din_eff;
    assign din_eff = rdy_prev_reg ? mem_din : skid_reg;

    // Byte i of a read is captured at step i+2.
    logic [31:0] rd_word;
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign rd_word[8*gi +: 8] = (idx_reg == 3'(gi + 2)) ? din_eff
                                                                : rbuf_reg[8*gi +: 8];
        end
    endgenerate

    logic [7:0] wr_byte;
    always_comb begin
        wr_byte = wdata_reg[7:0];
        case (idx_reg[1:0])
            2'd1:    wr_byte = wdata_reg[15:8];
            2'd2:    wr_byte = wdata_reg[23:16];
            2'd3:    wr_byte = wdata_reg[31:24];
            default: wr_byte = wdata_reg[7:0];
        endcase
    end

    // Arbitration: requesters keep ready high during their ok cycle, so no
    // grant is made while either ok is high.
    logic        grant_any;
    logic        grant_lsb;
    logic [31:0] sel_addr;
    logic [31:0] sel_data;
    logic [1:0]  sel_len;
    logic        sel_wr;
    assign grant_lsb = from_lsb_ready && (!from_if_ready || !last_grant_reg);
    assign grant_any = (state_reg == ST_IDLE) && !from_rob_set
                       && !to_if_ok_reg && !to_lsb_ok_reg
                       && (from_if_ready || from_lsb_ready);
    assign sel_addr  = grant_lsb ? from_lsb_addr : from_if_addr;
    assign sel_data  = grant_lsb ? from_lsb_data : 32'd0;
    assign sel_len   = grant_lsb ? from_lsb_len : 2'd3;
    assign sel_wr    = grant_lsb & from_lsb_wr;

    logic grant_stall;
    logic wr_stall;
`ifdef MCTR_IO_STALL_EN
    assign grant_stall = (sel_addr[17:16] == IO_BASE_HI) && io_buffer_full;
    assign wr_stall    = (cur_addr[17:16] == IO_BASE_HI) && io_buffer_full;
`else
    logic unused_io;
    assign unused_io   = io_buffer_full;
    assign grant_stall = 1'b0;
    assign wr_stall    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            idx_reg         <= 3'd0;
            base_reg        <= 32'd0;
            len_reg         <= 2'd0;
            wdata_reg       <= 32'd0;
            owner_reg       <= 1'b0;
            last_grant_reg  <= 1'b1;
            rbuf_reg        <= 32'd0;
            mem_wr_reg      <= 1'b0;
            mem_a_reg       <= 32'd0;
            mem_dout_reg    <= 8'd0;
            to_if_ok_reg    <= 1'b0;
            to_lsb_ok_reg   <= 1'b0;
            to_if_data_reg  <= 32'd0;
            to_lsb_data_reg <= 32'd0;
            rdy_prev_reg    <= 1'b1;
            skid_reg        <= 8'd0;
        end else begin
            rdy_prev_reg <= rdy;
            if (!rdy && rdy_prev_reg) begin
                skid_reg <= mem_din;
            end
            if (rdy) begin
                to_if_ok_reg  <= 1'b0;
                to_lsb_ok_reg <= 1'b0;
                case (state_reg)
                    ST_IDLE: begin
                        if (grant_any) begin
                            base_reg       <= sel_addr;
                            len_reg        <= sel_len;
                            wdata_reg      <= sel_data;
                            owner_reg      <= grant_lsb;
                            last_grant_reg <= grant_lsb;
                            rbuf_reg       <= 32'd0;
                            mem_a_reg      <= sel_addr;
                            if (sel_wr) begin
                                state_reg    <= ST_WRITE;
                                mem_dout_reg <= sel_data[7:0];
                                mem_wr_reg   <= !grant_stall;
                                idx_reg      <= grant_stall ? 3'd0 : 3'd1;
                            end else begin
                                state_reg <= ST_READ;
                                idx_reg   <= 3'd1;
                            end
                        end
                    end
                    ST_READ: begin
                        if (from_rob_set) begin
                            state_reg <= ST_IDLE;
                        end else begin
                            rbuf_reg <= rd_word;
                            if (idx_reg < nbytes) begin
                                mem_a_reg <= cur_addr;
                            end
                            if (idx_reg == last_step) begin
                                state_reg <= ST_IDLE;
                                if (owner_reg) begin
                                    to_lsb_ok_reg   <= 1'b1;
                                    to_lsb_data_reg <= rd_word;
                                end else begin
                                    to_if_ok_reg    <= 1'b1;
                                    to_if_data_reg  <= rd_word;
                                end
                            end else begin
                                idx_reg <= idx_reg + 3'd1;
                            end
                        end
                    end
                    ST_WRITE: begin
                        // Stores are committed: flush is ignored here.
                        if (idx_reg == nbytes) begin
                            mem_wr_reg <= 1'b0;
                            state_reg  <= ST_IDLE;
                            if (owner_reg) begin
                                to_lsb_ok_reg <= 1'b1;
                            end else begin
                                to_if_ok_reg  <= 1'b1;
                            end
                        end else if (wr_stall) begin
                            mem_wr_reg <= 1'b0;
                        end else begin
                            mem_a_reg    <= cur_addr;
                            mem_dout_reg <= wr_byte;
                            mem_wr_reg   <= 1'b1;
                            idx_reg      <= idx_reg + 3'd1;
                        end
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
